// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key loader with even-parity check for an RLL-locked core.
// Ports: clk, rst_n, load_start, zeroize, ser_valid/ser_data/ser_ready,
//        key_out, key_valid, busy, err.
module rll_key_loader #(
    parameter int KEY_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 zeroize,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 ser_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        LOADED
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (zeroize) begin
            // Wipes all key material; err is kept so a failed load stays reported.
            state_d  = IDLE;
            shadow_d = '0;
            key_d    = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d  = SHIFT;
                        shadow_d = '0;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                    end
                end
                SHIFT: begin
                    if (ser_valid) begin
                        shadow_d[cnt_q] = ser_data;
                        if (cnt_q == LAST) begin
                            state_d = PARITY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (ser_valid) begin
                        // Even parity: key bits plus parity bit must XOR to 0.
                        if ((^shadow_q) ^ ser_data) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            key_d   = shadow_q;
                            state_d = LOADED;
                        end
                    end
                end
                LOADED: begin
                    if (load_start) begin
                        // Drop the old key on the same edge so no partial key is seen.
                        key_d    = '0;
                        state_d  = SHIFT;
                        shadow_d = '0;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ser_ready = (state_q == SHIFT) || (state_q == PARITY);
    assign busy      = ser_ready;
    assign key_valid = (state_q == LOADED);
    assign key_out   = key_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// tb_rll_key_loader: randomized self-checking bench for rll_key_loader
// against a transaction-level model of the key load protocol.
module tb_rll_key_loader;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_start = 1'b0;
    logic         zeroize = 1'b0;
    logic         ser_valid = 1'b0;
    logic         ser_data = 1'b0;
    logic         ser_ready;
    logic [W-1:0] key_out;
    logic         key_valid;
    logic         busy;
    logic         err;

    int n_chk = 0;
    int n_fail = 0;

    // Model: a load in progress collects bits; bit W is the parity bit.
    bit           m_loading;
    int           m_n;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_key;
    bit           m_kv;
    bit           m_err;

    rll_key_loader #(.KEY_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .zeroize    (zeroize),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_ready  (ser_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 0;
        m_n = 0;
        m_acc = '0;
        m_key = '0;
        m_kv = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit ls, input bit zr, input bit v, input bit d);
        if (zr) begin
            m_loading = 0;
            m_n = 0;
            m_acc = '0;
            m_key = '0;
            m_kv = 0;
        end else if (!m_loading) begin
            if (ls) begin
                m_loading = 1;
                m_n = 0;
                m_acc = '0;
                m_err = 0;
                m_key = '0;
                m_kv = 0;
            end
        end else if (v) begin
            if (m_n < W) begin
                m_acc[m_n] = d;
                m_n++;
            end else begin
                m_loading = 0;
                if (((^m_acc) ^ d) == 1'b0) begin
                    m_key = m_acc;
                    m_kv = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ser_ready", W'(ser_ready), W'(m_loading));
        check("busy", W'(busy), W'(m_loading));
        check("key_out", key_out, m_key);
        check("key_valid", W'(key_valid), W'(m_kv));
        check("err", W'(err), W'(m_err));
    endtask

    // Called just after a negedge: drive, clock, update model, compare.
    task automatic cycle(input bit ls, input bit zr, input bit v, input bit d);
        load_start = ls;
        zeroize = zr;
        ser_valid = v;
        ser_data = d;
        @(posedge clk);
        model_step(ls, zr, v, d);
        @(negedge clk);
        compare_all();
    endtask

    // Streams nbits of key (LSB first) plus parity when nbits > W.
    task automatic send(input logic [W-1:0] k, input bit par, input int nbits,
                        input bit stall, input bit noise_ls);
        logic [W:0] s;
        s = {par, k};
        for (int i = 0; i < nbits; i++) begin
            if (stall) begin
                int g;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++)
                    cycle(noise_ls && ($urandom_range(0, 3) == 0), 0, 0,
                          1'($urandom));
            end
            cycle(noise_ls && ($urandom_range(0, 7) == 0), 0, 1, s[i]);
        end
    endtask

    initial begin
        logic [W-1:0] rk;
        bit           rp;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_key_out", key_out, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_ready", W'(ser_ready), '0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        compare_all();

        // Clean load; load_start edge is edge 0.
        cycle(1, 0, 0, 0);
        check("busy_after_start", W'(busy), 1);
        send(32'hA5A50F0F, 1'b0, W + 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("kv_edge34", W'(key_valid), 1);
        check("clean_key", key_out, 32'hA5A50F0F);
        check("clean_err", W'(err), 0);
        check("clean_busy", W'(busy), 0);

        // Reload from LOADED with 0x00000001 and parity 1.
        cycle(1, 0, 0, 0);
        check("reload_clear", key_out, '0);
        send(32'h00000001, 1'b1, W + 1, 1, 1);
        cycle(0, 0, 0, 0);
        check("reload_key", key_out, 32'h00000001);

        // Parity fail.
        cycle(1, 0, 0, 0);
        send(32'hA5A50F0F, 1'b1, W + 1, 0, 0);
        check("pf_err", W'(err), 1);
        check("pf_key", key_out, '0);
        check("pf_kv", W'(key_valid), 0);
        cycle(1, 0, 0, 0);
        check("pf_err_cleared", W'(err), 0);

        // Same load with random stalls.
        send(32'hA5A50F0F, 1'b0, W + 1, 1, 1);
        cycle(0, 0, 0, 0);
        check("stall_key", key_out, 32'hA5A50F0F);

        // Zeroize mid-load (with a beat present) and in LOADED.
        cycle(1, 0, 0, 0);
        send(32'h12345678, 1'b1, 10, 0, 0);
        cycle(0, 1, 1, 1);
        check("zr_mid_busy", W'(busy), 0);
        check("zr_mid_key", key_out, '0);
        cycle(1, 0, 0, 0);
        send(32'h0000FFFF, 1'b0, W + 1, 0, 0);
        check("zr_pre_key", key_out, 32'h0000FFFF);
        cycle(0, 1, 0, 0);
        check("zr_loaded_key", key_out, '0);
        check("zr_loaded_kv", W'(key_valid), 0);
        cycle(1, 1, 0, 0);
        check("zr_wins_busy", W'(busy), 0);

        // Async reset at bit 20.
        cycle(1, 0, 0, 0);
        send(32'hDEADBEEF, 1'b0, 20, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy), 0);
        check("arst_ready", W'(ser_ready), 0);
        check("arst_key", key_out, '0);
        check("arst_kv", W'(key_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 0);
        send(32'hDEADBEEF, ^32'hDEADBEEF, W + 1, 1, 0);
        cycle(0, 0, 0, 0);
        check("arst_reload", key_out, 32'hDEADBEEF);

        // Random loads with random parity correctness and random interruptions.
        for (int t = 0; t < 20; t++) begin
            rk = $urandom;
            rp = (^rk) ^ ($urandom_range(0, 3) == 0);
            cycle(1, 0, 0, 0);
            if ($urandom_range(0, 4) == 0) begin
                send(rk, rp, $urandom_range(1, W), 1, 1);
                cycle($urandom_range(0, 1), 1, 1, 1'($urandom));
            end else begin
                send(rk, rp, W + 1, 1, 1);
            end
            cycle(0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
